// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handoff and redirect.
// The master modport is the fetch sequencer. The slave modport is its environment.
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr, imem_req, if_valid, if_instr, if_pc,
        input  imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_req, if_valid, if_instr, if_pc,
        output imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It owns the fetch PC and issues one word request
// at a time. Returned words go into a small prefetch FIFO that feeds decode.
// On a redirect, the FIFO is flushed and in-flight data is discarded.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    fetch_sequencer_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_DROP} state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_imem_addr;
    logic           r_imem_req;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_mem_pc    [FIFO_DEPTH];
    logic [31:0]    r_mem_instr [FIFO_DEPTH];

    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_count_nxt;
    logic [31:0]    w_redir_pc;
    logic [31:0]    w_pc_inc;
    logic           w_unused_rpc_lo;

    // Redirect wins over everything. A response that lands on the redirect cycle is dropped.
    assign w_pop       = (r_count != '0) && bus.id_ready;
    assign w_push      = (r_state == S_FETCH) && bus.imem_ready && !bus.redirect_valid;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_redir_pc  = {bus.redirect_pc[31:2], 2'b00};
    assign w_pc_inc    = r_fetch_pc + 32'd4;
    assign w_unused_rpc_lo = ^bus.redirect_pc[1:0];

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.if_valid  = (r_count != '0);
    assign bus.if_instr  = r_mem_instr[r_rd_ptr];
    assign bus.if_pc     = r_mem_pc[r_rd_ptr];

    // Fetch FSM: next state, fetch PC and registered memory-request outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_imem_req <= 1'b1;
            if ((r_state == S_FETCH || r_state == S_DROP) && !bus.imem_ready) begin
                // A request is still outstanding. Keep the old address until memory answers.
                r_state <= S_DROP;
            end else begin
                r_state     <= S_FETCH;
                r_imem_addr <= w_redir_pc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_FETCH;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= r_fetch_pc;
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_count_nxt == CW'(FIFO_DEPTH)) begin
                            r_state    <= S_FULL;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_imem_addr <= w_pc_inc;
                        end
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_state     <= S_FETCH;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                S_DROP: begin
                    if (bus.imem_ready) begin
                        r_state     <= S_FETCH;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch FIFO. Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-port MIPS instruction memory.
- Owns the fetch PC and issues one word request at a time on a req/ready handshake.
- Buffers returned words in a small prefetch FIFO and hands them to decode on a valid/ready handshake.
- Handles branch/jump redirects by flushing and discarding in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (word aligned)
FIFO_DEPTH, 2, prefetch buffer entries (power of 2, >=2)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory
imem_req  output  1  read request; held with stable imem_addr until imem_ready
imem_ready  input  1  read complete; imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
if_valid  output  1  FIFO head valid toward decode
if_instr  output  32  head instruction
if_pc  output  32  byte address of head instruction
id_ready  input  1  decode accepts head this cycle (pop when if_valid && id_ready)
redirect_valid  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, FIFO empty, if_valid=0, if_instr=0, if_pc=0.
- if_valid = (count!=0); if_instr/if_pc driven from the FIFO head.
- imem_addr = fetch_pc in FETCH; old address held in DROP.
- States:
  - IDLE: imem_req=0. Next cycle -> FETCH, or apply redirect if present.
  - FETCH: imem_req=1, imem_addr=fetch_pc. On imem_ready: push {fetch_pc, imem_rdata}, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0). If the FIFO is full after push and pop accounting -> FULL, else stay FETCH with the new address next cycle (back-to-back, 1 word/cycle max).
  - FULL: imem_req=0. On pop -> FETCH next cycle.
  - DROP: imem_req=1 with the old address held. On imem_ready: discard data, no push -> FETCH at the redirected fetch_pc.
- Redirect (highest priority, any state):
  - FIFO flushed (count=0 next cycle).
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From FETCH without same-cycle imem_ready -> DROP. From FETCH with same-cycle imem_ready -> response discarded, -> FETCH.
  - From IDLE/FULL/DROP -> FETCH (DROP stays DROP if imem_ready not yet seen).
  - A pop in the same cycle is overridden; if_valid=0 next cycle.
- Push and pop in the same cycle: count unchanged. A push into a full FIFO never occurs, because FULL blocks requests.
- FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- Minimum latency: reset release -> first if_valid = 2 cycles + memory latency (IDLE 1 cycle, request, push visible the cycle after imem_ready).
- Async reset mid-transaction: all state cleared immediately. The memory response that arrives after reset release is ignored, because imem_req restarts only from IDLE.

Test Plan:
- Reset with RESET_PC=0, memory ready 1 cycle after req, id_ready=1 -> if_pc 0,4,8,12 on consecutive cycles with matching words; imem_req low only in IDLE.
- id_ready=0 with FIFO_DEPTH=2 -> exactly 2 words buffered (pc 0,4), imem_req drops, state FULL. Raise id_ready -> pc 0 popped, fetch resumes at 8, no word lost or duplicated.
- Memory latency 3 cycles, redirect_pc=32'h40 asserted 1 cycle after req for pc 8 -> imem_addr holds 8 until ready, data discarded, next request addr 32'h40, next if_pc=32'h40.
- Redirect in the same cycle as imem_ready and a pop -> FIFO empty next cycle, returned word not pushed, next imem_addr = redirect target.
- redirect_pc=32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then wrap to 32'h0000_0000.
- Assert reset_n=0 mid-DROP -> outputs at reset values immediately; after release first imem_addr=RESET_PC.
